pxs_line_overlay: RTL

Parametrised pixel-stream overlay. It paints one horizontal or vertical line (configurable thickness, dashing and colour depth) onto a VGA stream that carries no RGB, and emits an RGB stream one clock later. Position and enable are taken at run time but held constant for a whole frame, and an optional frame-counted blink is available. It sits between the VGA sync generator and the stream mixers, as the generalised line/net primitive for the pong screen.

---
 rtl/pxs_pkg.sv | 24 ++
 rtl/pxs_frame_ctr.sv | 48 ++++
 rtl/pxs_line_overlay.sv | 88 ++++++++
 3 files changed

// File: rtl/pxs_pkg.sv
// rtl/pxs_pkg.sv - shared pixel-stream field offsets and named 3-bit colours
package pxs_pkg;

  // Stream layout, LSB first: ActiveVideo, VSync, HSync, YCoord, XCoord, then RGB on RGB streams.
  localparam int AV_OFS = 0;
  localparam int VS_OFS = 1;
  localparam int HS_OFS = 2;
  localparam int Y_OFS  = 3;

  function automatic int x_ofs(input int coord_w);
    return Y_OFS + coord_w;
  endfunction

  function automatic int rgb_ofs(input int coord_w);
    return Y_OFS + 2 * coord_w;
  endfunction

  localparam logic [2:0] CLR_BLACK = 3'b000;
  localparam logic [2:0] CLR_BLUE  = 3'b001;
  localparam logic [2:0] CLR_GREEN = 3'b010;
  localparam logic [2:0] CLR_RED   = 3'b100;
  localparam logic [2:0] CLR_WHITE = 3'b111;

endpackage

// File: rtl/pxs_frame_ctr.sv
// rtl/pxs_frame_ctr.sv - frame-start detector and frame-counted blink phase
// Only instantiated when PXS_LINE_BLINK_EN is defined.
module pxs_frame_ctr #(
  parameter int COORD_W      = 10,
  parameter int BLINK_FRAMES = 30
) (
  input  logic               px_clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  output logic               frame_start_o,
  output logic               blink_vis_o
);

  localparam int               CNT_W    = $clog2(BLINK_FRAMES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vis_q, vis_d;

  always_comb begin
    frame_start_o = (x_i == '0) && (y_i == '0);
    cnt_d         = cnt_q;
    vis_d         = vis_q;
    if (frame_start_o) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        vis_d = ~vis_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge px_clk) begin
    if (reset) begin
      cnt_q <= '0;
      vis_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      vis_q <= vis_d;
    end
  end

  // The registered phase is what the frame-start pixel itself sees; the new phase applies after it.
  assign blink_vis_o = vis_q;

endmodule

// File: rtl/pxs_line_overlay.sv
// rtl/pxs_line_overlay.sv - paints one frame-held horizontal/vertical line onto a VGA stream, 1-cycle latency
// Optional frame-counted blink is compiled in with PXS_LINE_BLINK_EN.
module pxs_line_overlay
  import pxs_pkg::*;
#(
  parameter int                 COORD_W      = 10,
  parameter int                 RGB_W        = 3,
  parameter int                 MODE         = 0,
  parameter int                 THICK        = 1,
  parameter int                 DASH_LOG2    = 0,
  parameter logic [RGB_W-1:0]   FG_COLOR     = {RGB_W{1'b1}},
  parameter logic [RGB_W-1:0]   BG_COLOR     = {RGB_W{1'b0}},
  parameter int                 BLINK_FRAMES = 30,
  parameter logic [COORD_W-1:0] POS_RST      = COORD_W'(245)
) (
  input  logic                           px_clk,
  input  logic                           reset,
  input  logic [COORD_W-1:0]             pos_i,
  input  logic                           en_i,
  input  logic [2*COORD_W+2:0]           VGAStr_i,
  output logic [2*COORD_W+2+RGB_W:0]     RGBStr_o
);

  localparam int               OUT_W     = 2 * COORD_W + 3 + RGB_W;
  localparam int               X_OFS     = x_ofs(COORD_W);
  localparam int               RGB_OFS   = rgb_ofs(COORD_W);
  localparam logic [COORD_W:0] THICK_EXT = (COORD_W + 1)'(THICK);

  logic [COORD_W-1:0] x, y, c, a;
  logic [COORD_W-1:0] pos_q, pos_d, pos_eff;
  logic               en_q, en_d, en_eff;
  logic               av, frame_start, blink_vis, hit, dash_on;
  logic [COORD_W:0]   line_end;
  logic [OUT_W-1:0]   rgb_str_q, rgb_str_d;

  assign x  = VGAStr_i[X_OFS +: COORD_W];
  assign y  = VGAStr_i[Y_OFS +: COORD_W];
  assign av = VGAStr_i[AV_OFS];

`ifdef PXS_LINE_BLINK_EN
  pxs_frame_ctr #(
    .COORD_W      (COORD_W),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_frame_ctr (
    .px_clk        (px_clk),
    .reset         (reset),
    .x_i           (x),
    .y_i           (y),
    .frame_start_o (frame_start),
    .blink_vis_o   (blink_vis)
  );
`else
  assign frame_start = (x == '0) && (y == '0);
  assign blink_vis   = 1'b1;
`endif

  always_comb begin
    // Frame-start pixel uses the live request so a new position draws from pixel (0,0).
    pos_eff = frame_start ? pos_i : pos_q;
    en_eff  = frame_start ? en_i  : en_q;
    pos_d   = pos_eff;
    en_d    = en_eff;
    c       = (MODE == 1) ? x : y;
    a       = (MODE == 1) ? y : x;
    // One extra bit keeps pos+THICK from wrapping, clipping the line at coordinate max.
    line_end = {1'b0, pos_eff} + THICK_EXT;
    hit      = (c >= pos_eff) && ({1'b0, c} < line_end);
    dash_on  = (DASH_LOG2 == 0) ? 1'b1 : ~a[DASH_LOG2];
    rgb_str_d = {{RGB_W{1'b0}}, VGAStr_i};
    rgb_str_d[RGB_OFS +: RGB_W] =
      (av && en_eff && hit && dash_on && blink_vis) ? FG_COLOR : BG_COLOR;
  end

  always_ff @(posedge px_clk) begin
    if (reset) begin
      pos_q     <= POS_RST;
      en_q      <= 1'b0;
      rgb_str_q <= '0;
    end else begin
      pos_q     <= pos_d;
      en_q      <= en_d;
      rgb_str_q <= rgb_str_d;
    end
  end

  assign RGBStr_o = rgb_str_q;

endmodule
